// File: rtl/pps_detector_pkg.sv
// pps_detector_pkg
//  Shared timing constants for the 1PPS link. The detector and the PPS
//  generator take their CLK_FREQ from the same constant here, so both ends
//  of a link agree on the nominal period for each radio clock domain.
//  No ports.
package pps_detector_pkg;

  localparam int PERIOD_W = 32;

  // Nominal clk cycles per PPS period, one constant per radio clock domain.
  localparam logic [31:0] CLK_FREQ_10M     = 32'd10_000_000;
  localparam logic [31:0] CLK_FREQ_61M44   = 32'd61_440_000;
  localparam logic [31:0] CLK_FREQ_122M88  = 32'd122_880_000;
  localparam logic [31:0] CLK_FREQ_245M76  = 32'd245_760_000;

  localparam logic [31:0] PPS_TOL_DEFAULT  = 32'd100;
  localparam logic [3:0]  PPS_LOCK_DEFAULT = 4'd4;

endpackage

// File: rtl/pps_detector_if.sv
// pps_detector_if
//  PPS link bundle between the detector and its consumers (time-keeper,
//  ref-clock status).
//   pps_in     raw PPS, asynchronous to the detector clock
//   pps_pulse  one-cycle strobe per detected rising edge
//   pps_valid  high while the detector is locked
//   pps_lost   one-cycle strobe on every loss of lock
//   period     clk cycles between the last two edges
//  master: detector side. slave: consumer / stimulus side.
interface pps_detector_if
  import pps_detector_pkg::*;
  ();
  logic                pps_in;
  logic                pps_pulse;
  logic                pps_valid;
  logic                pps_lost;
  logic [PERIOD_W-1:0] period;

  modport master (input pps_in, output pps_pulse, pps_valid, pps_lost, period);
  modport slave  (output pps_in, input pps_pulse, pps_valid, pps_lost, period);
endinterface

// File: rtl/pps_detector_sync.sv
// pps_detector_sync
//  Plain multi-flop synchronizer for a single asynchronous level.
//   clk      destination clock
//   reset_n  asynchronous active-low reset, flops clear to 0
//   din      asynchronous input
//   dout     synchronized output, STAGES clk of latency
module pps_detector_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], din};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign dout = sync_q[STAGES-1];
endmodule

// File: rtl/pps_detector.sv
// pps_detector
//  Receive end of a 1PPS link. Synchronizes pps_in, strobes one pulse per
//  rising edge, measures the edge-to-edge period in clk cycles and qualifies
//  the signal as locked / lost.
//   clk      sample clock
//   reset_n  asynchronous active-low reset
//   pps      link bundle (master side): pps_in in; pps_pulse, pps_valid,
//            pps_lost, period out
//  Latency: pps_pulse is seen 3 clk after the clk edge that first samples
//  pps_in high (2 sync stages + edge register); state, pps_valid, pps_lost
//  and period are registered alongside pps_pulse.
module pps_detector
  import pps_detector_pkg::*;
#(
  parameter logic [31:0] CLK_FREQ   = CLK_FREQ_10M,
  parameter logic [31:0] TOLERANCE  = PPS_TOL_DEFAULT,
  parameter logic [3:0]  LOCK_COUNT = PPS_LOCK_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  pps_detector_if.master pps
);
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef enum logic [1:0] {
    SEARCH = ST_SEARCH,
    CHECK  = ST_CHECK,
    LOCKED = ST_LOCKED
  } state_e;

  // Bounds in 33 bits: CLK_FREQ + TOLERANCE (+1) may not fit in 32.
  localparam logic [32:0] BOUND_LO = {1'b0, CLK_FREQ} - {1'b0, TOLERANCE};
  localparam logic [32:0] BOUND_HI = {1'b0, CLK_FREQ} + {1'b0, TOLERANCE};
  localparam logic [32:0] TIMEOUT  = BOUND_HI + 33'd1;

  logic        pps_sync;
  logic        prev_q, prev_d;
  logic        edge_q, edge_d;
  logic [31:0] count_q, count_d;
  logic [31:0] period_q, period_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  state_e      state_q, state_d;
  logic        pulse_q, pulse_d;
  logic        valid_q, valid_d;
  logic        lost_q, lost_d;
  logic        good, timeout;

  pps_detector_sync #(.STAGES(2)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (pps.pps_in),
    .dout    (pps_sync)
  );

  always_comb begin
    prev_d = pps_sync;
    // Rising edge is registered; the cycle edge_q is high is the "edge cycle"
    // for the counter and FSM.
    edge_d = pps_sync & ~prev_q;

    good    = ({1'b0, count_q} >= BOUND_LO) && ({1'b0, count_q} <= BOUND_HI);
    // Count keeps running past TIMEOUT, so this fires once per silent gap.
    timeout = !edge_q && ({1'b0, count_q} == TIMEOUT);

    count_d    = edge_q ? 32'd1
               : (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    period_d   = period_q;
    pulse_d    = edge_q;
    lost_d     = 1'b0;

    case (state_q)
      SEARCH: begin
        if (edge_q) begin
          state_d    = CHECK;
          good_cnt_d = 4'd0;
        end
      end
      CHECK: begin
        if (edge_q) begin
          period_d = count_q;
          if (good) begin
            if (good_cnt_q + 4'd1 == LOCK_COUNT) begin
              state_d    = LOCKED;
              good_cnt_d = 4'd0;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end else begin
            good_cnt_d = 4'd0;
          end
        end else if (timeout) begin
          state_d    = SEARCH;
          good_cnt_d = 4'd0;
        end
      end
      LOCKED: begin
        if (edge_q) begin
          period_d = count_q;
          if (!good) begin
            state_d    = CHECK;
            good_cnt_d = 4'd0;
            lost_d     = 1'b1;
          end
        end else if (timeout) begin
          state_d    = SEARCH;
          good_cnt_d = 4'd0;
          lost_d     = 1'b1;
        end
      end
      default: begin
        state_d    = SEARCH;
        good_cnt_d = 4'd0;
      end
    endcase

    valid_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= 1'b0;
      edge_q     <= 1'b0;
      count_q    <= 32'd0;
      period_q   <= 32'd0;
      good_cnt_q <= 4'd0;
      state_q    <= SEARCH;
      pulse_q    <= 1'b0;
      valid_q    <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      edge_q     <= edge_d;
      count_q    <= count_d;
      period_q   <= period_d;
      good_cnt_q <= good_cnt_d;
      state_q    <= state_d;
      pulse_q    <= pulse_d;
      valid_q    <= valid_d;
      lost_q     <= lost_d;
    end
  end

  assign pps.pps_pulse = pulse_q;
  assign pps.pps_valid = valid_q;
  assign pps.pps_lost  = lost_q;
  assign pps.period    = period_q;
endmodule
